// File: rtl/meat_pkg.sv
// Shared types and constants for the grill meat controller.
package meat_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_GRILL  = 2'd1,
    ST_FLIP   = 2'd2,
    ST_SERVED = 2'd3
  } meat_state_e;

  localparam logic [3:0] LVL_MAX = 4'd15;

  // Colour band upper bounds (inclusive) on the up-face level.
  localparam logic [3:0] BAND_RAW_MAX    = 4'd4;
  localparam logic [3:0] BAND_COOKED_MAX = 4'd9;
  localparam logic [3:0] BAND_WELL_MAX   = 4'd12;

  // Serve grading windows (inclusive).
  localparam logic [3:0] SCORE_OK_MIN   = 4'd5;
  localparam logic [3:0] SCORE_OK_MAX   = 4'd12;
  localparam logic [3:0] SCORE_BEST_MIN = 4'd7;
  localparam logic [3:0] SCORE_BEST_MAX = 4'd10;

  // RGB333 palette.
  localparam logic [8:0] MUSCLE_RAW    = 9'b111_010_011;
  localparam logic [8:0] FAT_RAW       = 9'b111_111_111;
  localparam logic [8:0] MUSCLE_COOKED = 9'b101_011_001;
  localparam logic [8:0] FAT_COOKED    = 9'b111_110_100;
  localparam logic [8:0] MUSCLE_WELL   = 9'b011_010_000;
  localparam logic [8:0] FAT_WELL      = 9'b110_100_010;
  localparam logic [8:0] MUSCLE_BURNT  = 9'b001_001_001;
  localparam logic [8:0] FAT_BURNT     = 9'b010_010_010;

  // Grade a serve from both face levels.
  function automatic logic [1:0] grade(input logic [3:0] a, input logic [3:0] b);
    logic [1:0] g;
    if (a < SCORE_OK_MIN || a > SCORE_OK_MAX || b < SCORE_OK_MIN || b > SCORE_OK_MAX)
      g = 2'd0;
    else if (a >= SCORE_BEST_MIN && a <= SCORE_BEST_MAX &&
             b >= SCORE_BEST_MIN && b <= SCORE_BEST_MAX)
      g = 2'd3;
    else
      g = 2'd2;
    return g;
  endfunction

endpackage

// File: rtl/meat_cook_ctrl_if.sv
// Command inputs and sprite/status outputs of the meat controller.
interface meat_cook_ctrl_if;
  logic       start;
  logic       flip;
  logic       serve;
  logic [8:0] colour_fat;
  logic [8:0] colour_muscle;
  logic [7:0] x_adder;
  logic [7:0] y_adder;
  logic [1:0] state;
  logic       burnt;
  logic [1:0] score;
  logic       done;

  modport master (
    output start, flip, serve,
    input  colour_fat, colour_muscle, x_adder, y_adder, state, burnt, score, done
  );

  modport slave (
    input  start, flip, serve,
    output colour_fat, colour_muscle, x_adder, y_adder, state, burnt, score, done
  );
endinterface

// File: rtl/meat_palette.sv
// Maps a 4-bit cook level to its fat/muscle RGB333 colours.
module meat_palette
  import meat_pkg::*;
(
  input  logic [3:0] level,
  output logic [8:0] colour_fat,
  output logic [8:0] colour_muscle
);

  // Band decode
  always_comb begin
    colour_fat    = FAT_BURNT;
    colour_muscle = MUSCLE_BURNT;
    if (level <= BAND_RAW_MAX) begin
      colour_fat    = FAT_RAW;
      colour_muscle = MUSCLE_RAW;
    end else if (level <= BAND_COOKED_MAX) begin
      colour_fat    = FAT_COOKED;
      colour_muscle = MUSCLE_COOKED;
    end else if (level <= BAND_WELL_MAX) begin
      colour_fat    = FAT_WELL;
      colour_muscle = MUSCLE_WELL;
    end
  end

endmodule

// File: rtl/meat_cook_ctrl.sv
// Grill-state controller: cook levels per face, place/flip/serve, sprite position, serve grade.
module meat_cook_ctrl
  import meat_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = 50_000_000,
  parameter int unsigned FLIP_TICKS     = 12_500_000,
  parameter logic [7:0]  X_HOME         = 8'd10,
  parameter logic [7:0]  Y_HOME         = 8'd90,
  parameter logic [7:0]  X_GRILL        = 8'd70,
  parameter logic [7:0]  Y_GRILL        = 8'd60,
  parameter logic [7:0]  LIFT           = 8'd8
) (
  input  logic              clk,
  input  logic              resetn,
  meat_cook_ctrl_if.slave   bus
);

  localparam int unsigned PW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam int unsigned FW = (FLIP_TICKS > 1) ? $clog2(FLIP_TICKS) : 1;

  meat_state_e state_q, state_d;
  logic [PW-1:0] presc_q, presc_d;
  logic [FW-1:0] flip_cnt_q, flip_cnt_d;
  logic [3:0] lvl_a_q, lvl_a_d, lvl_b_q, lvl_b_d;
  logic side_q, side_d;
  logic [1:0] score_q, score_d;
  logic done_q, done_d;
  logic start_prev_q, flip_prev_q, serve_prev_q;

  logic start_cmd, flip_cmd, serve_cmd;
  logic step_wrap, flip_tc;
  logic [3:0] down_lvl, up_lvl, down_inc;

  assign start_cmd = bus.start & ~start_prev_q;
  assign flip_cmd  = bus.flip  & ~flip_prev_q;
  assign serve_cmd = bus.serve & ~serve_prev_q;

  assign step_wrap = (presc_q == PW'(TICKS_PER_STEP - 1));
  assign flip_tc   = (flip_cnt_q == FW'(FLIP_TICKS - 1));

  assign down_lvl = side_q ? lvl_b_q : lvl_a_q;
  assign up_lvl   = side_q ? lvl_a_q : lvl_b_q;
  assign down_inc = (down_lvl == LVL_MAX) ? LVL_MAX : down_lvl + 4'd1;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      presc_q      <= '0;
      flip_cnt_q   <= '0;
      lvl_a_q      <= 4'd0;
      lvl_b_q      <= 4'd0;
      side_q       <= 1'b0;
      score_q      <= 2'd0;
      done_q       <= 1'b0;
      start_prev_q <= 1'b0;
      flip_prev_q  <= 1'b0;
      serve_prev_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      flip_cnt_q   <= flip_cnt_d;
      lvl_a_q      <= lvl_a_d;
      lvl_b_q      <= lvl_b_d;
      side_q       <= side_d;
      score_q      <= score_d;
      done_q       <= done_d;
      start_prev_q <= bus.start;
      flip_prev_q  <= bus.flip;
      serve_prev_q <= bus.serve;
    end
  end

  // Next-state decode; serve wins over flip in GRILL
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (start_cmd) state_d = ST_GRILL;
      ST_GRILL: begin
        if (serve_cmd)     state_d = ST_SERVED;
        else if (flip_cmd) state_d = ST_FLIP;
      end
      ST_FLIP:   if (flip_tc) state_d = ST_GRILL;
      ST_SERVED: if (start_cmd) state_d = ST_GRILL;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Datapath updates: prescaler, cooking, flip timing, score latch
  always_comb begin
    presc_d    = presc_q;
    flip_cnt_d = flip_cnt_q;
    lvl_a_d    = lvl_a_q;
    lvl_b_d    = lvl_b_q;
    side_d     = side_q;
    score_d    = score_q;
    done_d     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        presc_d = '0;
        if (start_cmd) score_d = 2'd0;
      end
      ST_GRILL: begin
        presc_d = step_wrap ? '0 : presc_q + PW'(1);
        if (step_wrap) begin
          if (side_q) lvl_b_d = down_inc;
          else        lvl_a_d = down_inc;
        end
        if (serve_cmd) begin
          score_d = grade(lvl_a_q, lvl_b_q);
          done_d  = 1'b1;
        end
      end
      ST_FLIP: begin
        if (flip_tc) begin
          flip_cnt_d = '0;
          side_d     = ~side_q;
        end else begin
          flip_cnt_d = flip_cnt_q + FW'(1);
        end
      end
      ST_SERVED: begin
        if (start_cmd) begin
          lvl_a_d = 4'd0;
          lvl_b_d = 4'd0;
          side_d  = 1'b0;
          score_d = 2'd0;
          presc_d = '0;
        end
      end
      default: ;
    endcase
  end

  // Sprite position decode from current state
  always_comb begin
    bus.x_adder = X_HOME;
    bus.y_adder = Y_HOME;
    case (state_q)
      ST_GRILL: begin
        bus.x_adder = X_GRILL;
        bus.y_adder = Y_GRILL;
      end
      ST_FLIP: begin
        bus.x_adder = X_GRILL;
        bus.y_adder = Y_GRILL - LIFT;
      end
      default: ;
    endcase
  end

  meat_palette u_palette (
    .level         (up_lvl),
    .colour_fat    (bus.colour_fat),
    .colour_muscle (bus.colour_muscle)
  );

  assign bus.state = state_q;
  assign bus.burnt = (lvl_a_q == LVL_MAX) || (lvl_b_q == LVL_MAX);
  assign bus.score = score_q;
  assign bus.done  = done_q;

endmodule
